// File: rtl/mem_bus_arbiter_if.sv
// One memory-style request/completion port: command/address/data travel
// toward memory, and response/tag/data_out travel back to the requester.
interface mem_bus_arbiter_if;
    logic [1:0]  command;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  response;
    logic [3:0]  tag;
    logic [63:0] data_out;

    modport master (
        output command, addr, data,
        input  response, tag, data_out
    );

    modport slave (
        input  command, addr, data,
        output response, tag, data_out
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between the Dcache MSHR and the Icache,
// tracks which requester owns each outstanding load tag, and steers completions.
module mem_bus_arbiter #(
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    mem_bus_arbiter_if.slave        dcache,
    mem_bus_arbiter_if.slave        icache,
    mem_bus_arbiter_if.master       mem,
    output logic [4:0]              outstanding,
    output logic                    mem_idle,
    output logic                    spurious_tag
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    logic [NUM_TAGS-1:0] entry_valid;
    logic [NUM_TAGS-1:0] entry_owner;
    logic [2:0]          starve_cnt;

    logic d_req;
    logic i_req;
    logic d_wins;
    logic i_wins;
    logic alloc_load;
    logic entry_hit;

    // The Dcache normally has priority; once the Icache has been held off
    // long enough the counter hands it the port for one grant.
    always_comb begin
        d_req  = (dcache.command != BUS_NONE);
        i_req  = (icache.command != BUS_NONE);
        i_wins = i_req && (!d_req || (starve_cnt == STARVE_MAX));
        d_wins = d_req && !i_wins;

        mem.command     = BUS_NONE;
        mem.addr        = '0;
        mem.data        = '0;
        dcache.response = '0;
        icache.response = '0;

        if (i_wins) begin
            mem.command     = icache.command;
            mem.addr        = icache.addr;
            mem.data        = icache.data;
            icache.response = mem.response;
        end else if (d_wins) begin
            mem.command     = dcache.command;
            mem.addr        = dcache.addr;
            mem.data        = dcache.data;
            dcache.response = mem.response;
        end
    end

    // Completions are looked up in the registered table, so a tag that is
    // reissued this cycle still routes to its previous owner.
    always_comb begin
        alloc_load = (mem.command == BUS_LOAD) && (mem.response != 4'd0);
        entry_hit  = (mem.tag != 4'd0) && entry_valid[mem.tag];

        dcache.tag      = '0;
        dcache.data_out = '0;
        icache.tag      = '0;
        icache.data_out = '0;

        if (entry_hit) begin
            if (entry_owner[mem.tag]) begin
                icache.tag      = mem.tag;
                icache.data_out = mem.data_out;
            end else begin
                dcache.tag      = mem.tag;
                dcache.data_out = mem.data_out;
            end
        end

        mem_idle = (outstanding == 5'd0) && (mem.command == BUS_NONE);
    end

    // Clearing the completed entry before allocating lets a same-cycle
    // reissue of that tag leave the entry valid under its new owner.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry_valid  <= '0;
            entry_owner  <= '0;
            outstanding  <= '0;
            spurious_tag <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            if (entry_hit) begin
                entry_valid[mem.tag] <= 1'b0;
            end
            if (alloc_load) begin
                entry_valid[mem.response] <= 1'b1;
                entry_owner[mem.response] <= i_wins;
            end

            case ({alloc_load, entry_hit})
                2'b10:   outstanding <= outstanding + 5'd1;
                2'b01:   outstanding <= outstanding - 5'd1;
                default: outstanding <= outstanding;
            endcase

            if ((mem.tag != 4'd0) && !entry_hit) begin
                spurious_tag <= 1'b1;
            end

            if (i_req && !(i_wins && (mem.response != 4'd0))) begin
                if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 3'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule
